// File: rtl/or_sticky_collector.sv
// Sticky event collector: per-channel synchronisers feed level/edge set logic into
// pending and overflow registers, with a registered masked-OR summary and lowest-index encoder.
module or_sticky_collector #(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned SYNC_STAGES = 2,
    parameter  int unsigned EDGE_MODE   = 0,
    localparam int unsigned IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] MASK,
    input  logic [WIDTH-1:0] CLR,
    output logic [WIDTH-1:0] PEND,
    output logic [WIDTH-1:0] OVF,
    output logic             Y,
    output logic [IDX_W-1:0] FIRST
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic             y_q, y_d;
    logic [IDX_W-1:0] first_q, first_d;

    // Synchroniser chain; zero stages samples A directly
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = A;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge CLK or negedge R) begin
            if (!R) begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= A;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    // Set, sticky update and summary computed from the post-update pending vector
    always_comb begin
        set     = '0;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        masked  = '0;
        y_d     = 1'b0;
        first_d = '0;

        set    = (EDGE_MODE != 0) ? (s & ~p_q) : s;
        pend_d = (pend_q & ~CLR) | set;
        ovf_d  = (ovf_q & ~CLR) | (set & pend_q & ~CLR);
        masked = pend_d & MASK;
        y_d    = |masked;
        // Scan high to low so the lowest set index is the last one written
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                first_d = IDX_W'(unsigned'(i));
            end
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            p_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            y_q     <= 1'b0;
            first_q <= '0;
        end else begin
            p_q     <= s;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            y_q     <= y_d;
            first_q <= first_d;
        end
    end

    assign PEND  = pend_q;
    assign OVF   = ovf_q;
    assign Y     = y_q;
    assign FIRST = first_q;

endmodule

// File: tb/tb_or_sticky_collector.sv
// Directed bench for or_sticky_collector across level/edge modes, widths and synchroniser depths.
module tb_or_sticky_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // u0: W8 SS2 level mode
    logic [7:0] a0, mask0, clr0, pend0, ovf0;
    logic       y0;
    logic [2:0] first0;
    // u1: W8 SS2 edge mode
    logic [7:0] a1, mask1, clr1, pend1, ovf1;
    logic       y1;
    logic [2:0] first1;
    // u2: W2 SS0 edge mode
    logic [1:0] a2, mask2, clr2, pend2, ovf2;
    logic       y2;
    logic [0:0] first2;
    // u3: W32 SS3 level mode
    logic [31:0] a3, mask3, clr3, pend3, ovf3;
    logic        y3;
    logic [4:0]  first3;

    or_sticky_collector #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) u0 (
        .CLK(clk), .R(rst_n), .A(a0), .MASK(mask0), .CLR(clr0),
        .PEND(pend0), .OVF(ovf0), .Y(y0), .FIRST(first0));
    or_sticky_collector #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(1)) u1 (
        .CLK(clk), .R(rst_n), .A(a1), .MASK(mask1), .CLR(clr1),
        .PEND(pend1), .OVF(ovf1), .Y(y1), .FIRST(first1));
    or_sticky_collector #(.WIDTH(2), .SYNC_STAGES(0), .EDGE_MODE(1)) u2 (
        .CLK(clk), .R(rst_n), .A(a2), .MASK(mask2), .CLR(clr2),
        .PEND(pend2), .OVF(ovf2), .Y(y2), .FIRST(first2));
    or_sticky_collector #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_MODE(0)) u3 (
        .CLK(clk), .R(rst_n), .A(a3), .MASK(mask3), .CLR(clr3),
        .PEND(pend3), .OVF(ovf3), .Y(y3), .FIRST(first3));

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        clr0 = '0; clr1 = '0; clr2 = '0; clr3 = '0;
        mask0 = '1; mask1 = '1; mask2 = '1; mask3 = '1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (pend0 !== 8'h00 || ovf0 !== 8'h00 || y0 !== 1'b0 || first0 !== 3'd0) begin
            errors++;
            $display("FAIL reset_u0 pend=%h ovf=%h y=%b first=%0d expected all 0", pend0, ovf0, y0, first0);
        end
        checks++;
        if (pend3 !== 32'h0 || ovf3 !== 32'h0 || y3 !== 1'b0 || first3 !== 5'd0) begin
            errors++;
            $display("FAIL reset_u3 pend=%h ovf=%h y=%b first=%0d expected all 0", pend3, ovf3, y3, first3);
        end
    endtask

    task automatic test_level_capture();
        apply_reset();
        a0 = 8'h20;
        tick(1);
        a0 = 8'h00;
        tick(1);
        checks++;
        if (pend0 !== 8'h00 || y0 !== 1'b0) begin
            errors++;
            $display("FAIL level_early pend=%h y=%b expected pend=00 y=0 after edge 1", pend0, y0);
        end
        tick(1);
        checks++;
        if (pend0 !== 8'h20 || y0 !== 1'b1 || first0 !== 3'd5 || ovf0 !== 8'h00) begin
            errors++;
            $display("FAIL level_edge2 pend=%h y=%b first=%0d ovf=%h expected 20/1/5/00", pend0, y0, first0, ovf0);
        end
        tick(4);
        checks++;
        if (pend0 !== 8'h20 || y0 !== 1'b1) begin
            errors++;
            $display("FAIL level_sticky pend=%h y=%b expected pend=20 y=1", pend0, y0);
        end
        clr0 = 8'h20;
        tick(1);
        clr0 = 8'h00;
        checks++;
        if (pend0 !== 8'h00 || y0 !== 1'b0 || first0 !== 3'd0) begin
            errors++;
            $display("FAIL level_clear pend=%h y=%b first=%0d expected 00/0/0", pend0, y0, first0);
        end
    endtask

    task automatic test_priority_mask();
        apply_reset();
        a0 = 8'h48;
        tick(1);
        a0 = 8'h00;
        tick(2);
        checks++;
        if (first0 !== 3'd3 || y0 !== 1'b1 || pend0 !== 8'h48) begin
            errors++;
            $display("FAIL prio_lowest first=%0d y=%b pend=%h expected 3/1/48", first0, y0, pend0);
        end
        mask0 = 8'hF7;
        tick(1);
        checks++;
        if (first0 !== 3'd6 || y0 !== 1'b1) begin
            errors++;
            $display("FAIL prio_mask3 first=%0d y=%b expected 6/1", first0, y0);
        end
        mask0 = 8'h00;
        tick(1);
        checks++;
        if (first0 !== 3'd0 || y0 !== 1'b0 || pend0 !== 8'h48) begin
            errors++;
            $display("FAIL prio_mask_all first=%0d y=%b pend=%h expected 0/0/48", first0, y0, pend0);
        end
        mask0 = 8'h40;
        tick(1);
        checks++;
        if (first0 !== 3'd6 || y0 !== 1'b1) begin
            errors++;
            $display("FAIL prio_unmask first=%0d y=%b expected 6/1", first0, y0);
        end
    endtask

    task automatic test_level_hold_overflow();
        apply_reset();
        a0 = 8'h01;
        tick(3);
        checks++;
        if (pend0 !== 8'h01 || ovf0 !== 8'h00 || y0 !== 1'b1 || first0 !== 3'd0) begin
            errors++;
            $display("FAIL hold_first pend=%h ovf=%h y=%b first=%0d expected 01/00/1/0", pend0, ovf0, y0, first0);
        end
        tick(1);
        checks++;
        if (ovf0 !== 8'h01) begin
            errors++;
            $display("FAIL hold_ovf ovf=%h expected 01", ovf0);
        end
    endtask

    task automatic test_edge_overflow();
        apply_reset();
        a1 = 8'h02;
        tick(3);
        checks++;
        if (pend1 !== 8'h02 || ovf1 !== 8'h00 || first1 !== 3'd1) begin
            errors++;
            $display("FAIL edge_first pend=%h ovf=%h first=%0d expected 02/00/1", pend1, ovf1, first1);
        end
        tick(3);
        checks++;
        if (ovf1 !== 8'h00) begin
            errors++;
            $display("FAIL edge_held ovf=%h expected 00", ovf1);
        end
        a1 = 8'h00;
        tick(3);
        a1 = 8'h02;
        tick(3);
        checks++;
        if (pend1 !== 8'h02 || ovf1 !== 8'h02) begin
            errors++;
            $display("FAIL edge_second pend=%h ovf=%h expected 02/02", pend1, ovf1);
        end
        clr1 = 8'h02;
        tick(1);
        clr1 = 8'h00;
        checks++;
        if (pend1 !== 8'h00 || ovf1 !== 8'h00) begin
            errors++;
            $display("FAIL edge_clear pend=%h ovf=%h expected 00/00", pend1, ovf1);
        end
        a1 = 8'h00;
    endtask

    task automatic test_set_clear_collision();
        apply_reset();
        a1 = 8'h04;
        tick(1);
        a1 = 8'h00;
        tick(4);
        a1 = 8'h04;
        tick(1);
        a1 = 8'h00;
        tick(1);
        clr1 = 8'h04;
        tick(1);
        clr1 = 8'h00;
        checks++;
        if (pend1[2] !== 1'b1 || ovf1[2] !== 1'b0) begin
            errors++;
            $display("FAIL set_clr_collide pend2=%b ovf2=%b expected 1/0", pend1[2], ovf1[2]);
        end
    endtask

    task automatic test_reset_mid_operation();
        apply_reset();
        a0 = 8'hFF;
        tick(4);
        checks++;
        if (pend0 !== 8'hFF || ovf0 !== 8'hFF) begin
            errors++;
            $display("FAIL mid_setup pend=%h ovf=%h expected FF/FF", pend0, ovf0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pend0 !== 8'h00 || ovf0 !== 8'h00 || y0 !== 1'b0 || first0 !== 3'd0) begin
            errors++;
            $display("FAIL mid_async pend=%h ovf=%h y=%b first=%0d expected all 0", pend0, ovf0, y0, first0);
        end
        a0 = 8'h00;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_release_edge();
        a1 = 8'h00;
        clr1 = 8'h00;
        rst_n = 1'b0;
        a1 = 8'h01;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (pend1 !== 8'h00) begin
            errors++;
            $display("FAIL release_early pend=%h expected 00", pend1);
        end
        tick(1);
        checks++;
        if (pend1 !== 8'h01 || ovf1 !== 8'h00) begin
            errors++;
            $display("FAIL release_set pend=%h ovf=%h expected 01/00", pend1, ovf1);
        end
        tick(4);
        clr1 = 8'h01;
        tick(1);
        clr1 = 8'h00;
        tick(3);
        checks++;
        if (pend1 !== 8'h00 || ovf1 !== 8'h00) begin
            errors++;
            $display("FAIL release_once pend=%h ovf=%h expected 00/00", pend1, ovf1);
        end
        a1 = 8'h00;
    endtask

    task automatic test_width2_sync0();
        apply_reset();
        a2 = 2'b10;
        #1;
        checks++;
        if (pend2 !== 2'b00 || y2 !== 1'b0) begin
            errors++;
            $display("FAIL w2_no_comb pend=%b y=%b expected 00/0", pend2, y2);
        end
        tick(1);
        checks++;
        if (pend2 !== 2'b10 || y2 !== 1'b1 || first2 !== 1'b1) begin
            errors++;
            $display("FAIL w2_edge0 pend=%b y=%b first=%0d expected 10/1/1", pend2, y2, first2);
        end
        tick(1);
        a2 = 2'b11;
        tick(1);
        checks++;
        if (pend2 !== 2'b11 || ovf2 !== 2'b00 || first2 !== 1'b0 || y2 !== 1'b1) begin
            errors++;
            $display("FAIL w2_both pend=%b ovf=%b first=%0d y=%b expected 11/00/0/1", pend2, ovf2, first2, y2);
        end
        a2 = 2'b00;
    endtask

    task automatic test_width32_sync3();
        apply_reset();
        a3 = 32'h8000_0000;
        tick(1);
        a3 = 32'h0;
        tick(2);
        checks++;
        if (pend3 !== 32'h0) begin
            errors++;
            $display("FAIL w32_edge2 pend=%h expected 00000000", pend3);
        end
        tick(1);
        checks++;
        if (pend3 !== 32'h8000_0000 || first3 !== 5'd31 || y3 !== 1'b1) begin
            errors++;
            $display("FAIL w32_edge3 pend=%h first=%0d y=%b expected 80000000/31/1", pend3, first3, y3);
        end
        a3 = 32'h0001_0000;
        tick(1);
        a3 = 32'h0;
        tick(3);
        checks++;
        if (pend3 !== 32'h8001_0000 || first3 !== 5'd16 || ovf3 !== 32'h0) begin
            errors++;
            $display("FAIL w32_second pend=%h first=%0d ovf=%h expected 80010000/16/0", pend3, first3, ovf3);
        end
    endtask

    initial begin
        test_reset();
        test_level_capture();
        test_priority_mask();
        test_level_hold_overflow();
        test_edge_overflow();
        test_set_clear_collision();
        test_reset_mid_operation();
        test_reset_release_edge();
        test_width2_sync0();
        test_width32_sync3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
